// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scan path.
//   kp_state_t      scan controller states
//   row_onehot_t    one-hot row strobe (bit r drives row r)
//   col_onehot_t    column sense vector (bit c = contact on column c)
//   is_onehot()     true when exactly one bit of a 4-bit vector is set
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef logic [NUM_ROWS-1:0] row_onehot_t;
  typedef logic [NUM_COLS-1:0] col_onehot_t;

  typedef enum logic [2:0] {IDLE, SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle.
//   enable     scanning enable (consumer -> scanner)
//   col_in     raw column lines from the pads (pads -> scanner)
//   row_out    one-hot row strobe (scanner -> pads)
//   key_value  last accepted key code
//   key_valid  one-cycle pulse per accepted press
//   key_held   high while the accepted key is still down
//   multi_key  one-cycle pulse when a sampled row shows several columns
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic        enable;
  col_onehot_t col_in;
  row_onehot_t row_out;
  logic [3:0]  key_value;
  logic        key_valid;
  logic        key_held;
  logic        multi_key;

  modport master (output enable, col_in,
                  input  row_out, key_value, key_valid, key_held, multi_key);
  modport slave  (input  enable, col_in,
                  output row_out, key_value, key_valid, key_held, multi_key);
endinterface

// File: rtl/keypad_scanner_decoder.sv
// KeypadDecoder: maps a one-hot {row, col} pair to key code row*NUM_COLS+col.
//   row    one-hot row strobe
//   col    one-hot column vector
//   value  key code, $clog2(BASE) bits
//   valid  both inputs one-hot and code below BASE
module KeypadDecoder
  import keypad_pkg::*;
#(
  parameter int BASE = 16,
  localparam int VW  = $clog2(BASE)
) (
  input  row_onehot_t   row,
  input  col_onehot_t   col,
  output logic [VW-1:0] value,
  output logic          valid
);

  int r_i, c_i, code;

  always_comb begin
    r_i = 0;
    c_i = 0;
    for (int i = 0; i < NUM_ROWS; i++) if (row[i]) r_i = i;
    for (int i = 0; i < NUM_COLS; i++) if (col[i]) c_i = i;
    code  = r_i * NUM_COLS + c_i;
    valid = is_onehot(row) && is_onehot(col) && (code < BASE);
    value = VW'(code);
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scan controller: strobes rows, synchronises and debounces the
// column lines and emits one key event per physical press.
//   clk, rst_n   clock, asynchronous active-low reset
//   kp (slave)   enable/col_in in; row_out, key_value, key_valid,
//                key_held, multi_key out
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  keypad_scanner_if.slave  kp
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  kp_state_t     state, state_n;
  logic [1:0]    row_idx, row_idx_n;
  logic [SW-1:0] set_cnt, set_cnt_n;
  logic [DW-1:0] deb_cnt, deb_cnt_n;
  row_onehot_t   cand_row, cand_row_n, row_strobe;
  col_onehot_t   cand_col, cand_col_n, col_m, col_s;
  logic [3:0]    key_value_n, dec_value;
  logic          key_valid_n, key_held_n, multi_key_n, dec_valid;

  KeypadDecoder #(.BASE(16)) u_dec (
    .row   (cand_row),
    .col   (cand_col),
    .value (dec_value),
    .valid (dec_valid)
  );

  assign row_strobe = row_onehot_t'(1) << row_idx;
  assign kp.row_out = (state == IDLE) ? '0 : row_strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_m        <= '0;
      col_s        <= '0;
      state        <= IDLE;
      row_idx      <= '0;
      set_cnt      <= '0;
      deb_cnt      <= '0;
      cand_row     <= '0;
      cand_col     <= '0;
      kp.key_value <= '0;
      kp.key_valid <= 1'b0;
      kp.key_held  <= 1'b0;
      kp.multi_key <= 1'b0;
    end else begin
      col_m        <= kp.col_in;
      col_s        <= col_m;
      state        <= state_n;
      row_idx      <= row_idx_n;
      set_cnt      <= set_cnt_n;
      deb_cnt      <= deb_cnt_n;
      cand_row     <= cand_row_n;
      cand_col     <= cand_col_n;
      kp.key_value <= key_value_n;
      kp.key_valid <= key_valid_n;
      kp.key_held  <= key_held_n;
      kp.multi_key <= multi_key_n;
    end
  end

  always_comb begin
    state_n     = state;
    row_idx_n   = row_idx;
    set_cnt_n   = set_cnt;
    deb_cnt_n   = deb_cnt;
    cand_row_n  = cand_row;
    cand_col_n  = cand_col;
    key_value_n = kp.key_value;
    key_valid_n = 1'b0;
    key_held_n  = kp.key_held;
    multi_key_n = 1'b0;
    if (!kp.enable) begin
      // Disable wins everywhere, including mid-press: no event is emitted.
      state_n    = IDLE;
      row_idx_n  = '0;
      set_cnt_n  = '0;
      deb_cnt_n  = '0;
      key_held_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n   = SCAN;
          row_idx_n = '0;
          set_cnt_n = '0;
        end
        SCAN: begin
          if (set_cnt != SET_LAST) begin
            set_cnt_n = set_cnt + 1'b1;
          end else begin
            // Sample cycle: settle window has covered the synchroniser.
            set_cnt_n = '0;
            if (col_s == '0) begin
              row_idx_n = row_idx + 2'd1;
            end else if (is_onehot(col_s)) begin
              cand_row_n = row_strobe;
              cand_col_n = col_s;
              deb_cnt_n  = '0;
              state_n    = DEBOUNCE;
            end else begin
              multi_key_n = 1'b1;
              row_idx_n   = row_idx + 2'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (col_s == cand_col && dec_valid) begin
            if (deb_cnt == DEB_LAST) begin
              key_value_n = dec_value;
              key_valid_n = 1'b1;
              key_held_n  = 1'b1;
              deb_cnt_n   = '0;
              state_n     = HELD;
            end else begin
              deb_cnt_n = deb_cnt + 1'b1;
            end
          end else begin
            // Retry the same row from a fresh settle window.
            deb_cnt_n = '0;
            set_cnt_n = '0;
            state_n   = SCAN;
          end
        end
        HELD: begin
          if (col_s != cand_col) begin
            deb_cnt_n = '0;
            state_n   = RELEASE;
          end
        end
        RELEASE: begin
          if ((col_s & cand_col) != '0) begin
            deb_cnt_n = '0;
            state_n   = HELD;
          end else if (deb_cnt == DEB_LAST) begin
            key_held_n = 1'b0;
            row_idx_n  = row_idx + 2'd1;
            set_cnt_n  = '0;
            deb_cnt_n  = '0;
            state_n    = SCAN;
          end else begin
            deb_cnt_n = deb_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a key-matrix model closes columns
// for the strobed row; expected key codes go into a queue and are popped by
// a monitor on every key_valid.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pressed = '0;
  int          total = 0, bad = 0, kv_cnt = 0, mk_cnt = 0;
  logic [3:0]  exp_q[$];

  always #5 clk = ~clk;

  keypad_scanner_if ifc ();

  keypad_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (ifc.slave)
  );

  // Key k sits at row k/4, column k%4.
  always_comb begin
    ifc.col_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (ifc.row_out[r] && pressed[r*4+c]) ifc.col_in[c] = 1'b1;
  end

  always @(negedge clk) begin
    if (ifc.key_valid) begin
      kv_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_key_valid got=%0h exp=none", ifc.key_value);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (ifc.key_value !== e) begin
          bad++;
          $display("FAIL key_value got=%0h exp=%0h", ifc.key_value, e);
        end
      end
    end
    if (ifc.multi_key) mk_cnt++;
    if (ifc.key_valid && ifc.multi_key) begin
      total++;
      bad++;
      $display("FAIL valid_and_multi got=1 exp=0");
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifc.enable = 1'b0;
    pressed    = '0;
    repeat (3) tick();
  endtask

  task automatic wait_row(input logic [3:0] row, input string tag);
    int n = 0;
    while (ifc.row_out !== row && n < 80) begin
      tick();
      n++;
    end
    total++;
    if (ifc.row_out !== row) begin
      bad++;
      $display("FAIL %s_row_timeout got=%b exp=%b", tag, ifc.row_out, row);
    end
  endtask

  task automatic test_reset();
    ifc.enable = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    total++;
    if ({ifc.row_out, ifc.key_value, ifc.key_valid, ifc.key_held, ifc.multi_key} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0", {ifc.row_out, ifc.key_value,
               ifc.key_valid, ifc.key_held, ifc.multi_key});
    end
    rst_n = 1'b1;
    repeat (4) tick();
    total++;
    if ({ifc.row_out, ifc.key_valid, ifc.key_held, ifc.multi_key} !== 7'd0) begin
      bad++;
      $display("FAIL idle_outputs got=%b exp=0", {ifc.row_out, ifc.key_valid,
               ifc.key_held, ifc.multi_key});
    end
  endtask

  task automatic test_scan_wrap();
    int kv0, mk0;
    logic [3:0] exp_row;
    idle_all();
    kv0 = kv_cnt;
    mk0 = mk_cnt;
    ifc.enable = 1'b1;
    tick();
    for (int i = 0; i < 25; i++) begin
      exp_row = 4'b0001 << ((i / 5) % 4);
      total++;
      if (ifc.row_out !== exp_row) begin
        bad++;
        $display("FAIL scan_row[%0d] got=%b exp=%b", i, ifc.row_out, exp_row);
      end
      tick();
    end
    total++;
    if (kv_cnt != kv0 || mk_cnt != mk0) begin
      bad++;
      $display("FAIL scan_no_pulses got=%0d/%0d exp=%0d/%0d", kv_cnt, mk_cnt, kv0, mk0);
    end
  endtask

  task automatic test_clean_press();
    int cyc;
    int kv0;
    idle_all();
    kv0 = kv_cnt;
    exp_q.push_back(4'h6);
    pressed[6] = 1'b1;
    ifc.enable = 1'b1;
    wait_row(4'b0010, "clean");
    // 5 scan cycles on the row, then 16 debounce cycles.
    cyc = 0;
    while (ifc.key_valid !== 1'b1 && cyc < 80) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc != 21) begin
      bad++;
      $display("FAIL clean_valid_latency got=%0d exp=21", cyc);
    end
    repeat (5) tick();
    total++;
    if (ifc.key_held !== 1'b1 || ifc.row_out !== 4'b0010) begin
      bad++;
      $display("FAIL clean_held got=%b/%b exp=1/0010", ifc.key_held, ifc.row_out);
    end
    pressed[6] = 1'b0;
    // 2 synchroniser cycles, 1 HELD detect cycle, 16 clean cycles.
    cyc = 0;
    while (ifc.key_held !== 1'b0 && cyc < 80) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc != 19) begin
      bad++;
      $display("FAIL clean_release_latency got=%0d exp=19", cyc);
    end
    total++;
    if (ifc.row_out !== 4'b0100) begin
      bad++;
      $display("FAIL clean_next_row got=%b exp=0100", ifc.row_out);
    end
    total++;
    if (kv_cnt != kv0 + 1) begin
      bad++;
      $display("FAIL clean_event_count got=%0d exp=%0d", kv_cnt - kv0, 1);
    end
  endtask

  task automatic test_bouncy_press();
    int kv0, cyc;
    idle_all();
    kv0 = kv_cnt;
    exp_q.push_back(4'hB);
    ifc.enable = 1'b1;
    wait_row(4'b0100, "bouncy");
    for (int i = 0; i < 6; i++) begin
      pressed[11] = ~i[0];
      tick();
    end
    pressed[11] = 1'b1;
    cyc = 0;
    while (ifc.key_held !== 1'b1 && cyc < 150) begin
      tick();
      cyc++;
    end
    repeat (4) tick();
    total++;
    if (kv_cnt != kv0 + 1 || ifc.key_held !== 1'b1) begin
      bad++;
      $display("FAIL bouncy_press got=%0d/%b exp=1/1", kv_cnt - kv0, ifc.key_held);
    end
    for (int i = 0; i < 3; i++) begin
      pressed[11] = i[0];
      tick();
    end
    pressed[11] = 1'b0;
    cyc = 0;
    while (ifc.key_held !== 1'b0 && cyc < 100) begin
      tick();
      cyc++;
    end
    repeat (30) tick();
    total++;
    if (kv_cnt != kv0 + 1 || ifc.key_held !== 1'b0) begin
      bad++;
      $display("FAIL bouncy_release got=%0d/%b exp=1/0", kv_cnt - kv0, ifc.key_held);
    end
  endtask

  task automatic test_multi_key();
    int kv0, mk0;
    idle_all();
    kv0 = kv_cnt;
    mk0 = mk_cnt;
    pressed[12] = 1'b1;
    pressed[14] = 1'b1;
    ifc.enable = 1'b1;
    wait_row(4'b1000, "multi");
    repeat (4) tick();
    total++;
    if (ifc.multi_key !== 1'b0) begin
      bad++;
      $display("FAIL multi_early got=%b exp=0", ifc.multi_key);
    end
    tick();
    total++;
    if (ifc.multi_key !== 1'b1 || ifc.row_out !== 4'b0001) begin
      bad++;
      $display("FAIL multi_pulse got=%b/%b exp=1/0001", ifc.multi_key, ifc.row_out);
    end
    pressed = '0;
    repeat (25) tick();
    total++;
    if (kv_cnt != kv0 || mk_cnt != mk0 + 1) begin
      bad++;
      $display("FAIL multi_counts got=%0d/%0d exp=0/1", kv_cnt - kv0, mk_cnt - mk0);
    end
  endtask

  task automatic test_enable_drop();
    int kv0, cyc;
    idle_all();
    kv0 = kv_cnt;
    exp_q.push_back(4'h3);
    pressed[3] = 1'b1;
    ifc.enable = 1'b1;
    cyc = 0;
    while (ifc.key_held !== 1'b1 && cyc < 80) begin
      tick();
      cyc++;
    end
    repeat (3) tick();
    total++;
    if (kv_cnt != kv0 + 1 || ifc.key_held !== 1'b1) begin
      bad++;
      $display("FAIL drop_first_press got=%0d/%b exp=1/1", kv_cnt - kv0, ifc.key_held);
    end
    ifc.enable = 1'b0;
    tick();
    total++;
    if (ifc.row_out !== 4'b0000 || ifc.key_held !== 1'b0) begin
      bad++;
      $display("FAIL drop_idle got=%b/%b exp=0000/0", ifc.row_out, ifc.key_held);
    end
    repeat (10) tick();
    total++;
    if (kv_cnt != kv0 + 1) begin
      bad++;
      $display("FAIL drop_no_event got=%0d exp=1", kv_cnt - kv0);
    end
    exp_q.push_back(4'h3);
    ifc.enable = 1'b1;
    tick();
    total++;
    if (ifc.row_out !== 4'b0001) begin
      bad++;
      $display("FAIL reenable_row got=%b exp=0001", ifc.row_out);
    end
    cyc = 0;
    while (ifc.key_valid !== 1'b1 && cyc < 80) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc != 21) begin
      bad++;
      $display("FAIL reenable_latency got=%0d exp=21", cyc);
    end
  endtask

  task automatic test_async_reset();
    // Key 3 is still held from the previous scenario.
    total++;
    if (ifc.key_held !== 1'b1) begin
      bad++;
      $display("FAIL areset_precond got=%b exp=1", ifc.key_held);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ifc.row_out, ifc.key_value, ifc.key_valid, ifc.key_held, ifc.multi_key} !== 11'd0) begin
      bad++;
      $display("FAIL areset_outputs got=%b exp=0", {ifc.row_out, ifc.key_value,
               ifc.key_valid, ifc.key_held, ifc.multi_key});
    end
    ifc.enable = 1'b0;
    pressed    = '0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    ifc.enable = 1'b0;
    test_reset();
    test_scan_wrap();
    test_clean_press();
    test_bouncy_press();
    test_multi_key();
    test_enable_drop();
    test_async_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
